// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control and status bundle between decode and the PC stage
interface pc_sequencer_if;
  logic        Stall;
  logic        Branch;
  logic        Jump;
  logic [31:0] offset;
  logic [25:0] jump;
  logic        Halt;
  logic        Resume;
  logic [31:0] PC;
  logic        PCValid;
  logic        Halted;
  logic        Fault;
  logic [31:0] RetireCount;

  modport master (
    output Stall, Branch, Jump, offset, jump, Halt, Resume,
    input  PC, PCValid, Halted, Fault, RetireCount
  );

  modport slave (
    input  Stall, Branch, Jump, offset, jump, Halt, Resume,
    output PC, PCValid, Halted, Fault, RetireCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with run/halt/fault control and retire counter
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          IMEM_DEPTH = 17
) (
  input  logic         CLK,
  input  logic         Reset,
  pc_sequencer_if.slave bus
);

  localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retire_q, retire_d;
  logic [31:0] next_pc;
  logic [31:0] inc_pc;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      retire_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    retire_d = retire_q;
    inc_pc   = pc_q + 32'd1;
    next_pc  = inc_pc;
    if (bus.Jump) begin
      next_pc = {pc_q[31:26], bus.jump};
    end else if (bus.Branch) begin
      next_pc = inc_pc + bus.offset;
    end

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.Halt) begin
          state_d  = HALT;
          retire_d = retire_q + 32'd1;
        end else if (!bus.Stall) begin
          // An out-of-range target still retires the instruction but freezes the PC.
          retire_d = retire_q + 32'd1;
          if (next_pc >= DEPTH) begin
            state_d = FAULT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HALT: begin
        if (bus.Resume) begin
          if (inc_pc >= DEPTH) begin
            state_d = FAULT;
          end else begin
            state_d = RUN;
            pc_d    = inc_pc;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  assign bus.PC          = pc_q;
  assign bus.PCValid     = (state_q == RUN);
  assign bus.Halted      = (state_q == HALT);
  assign bus.Fault       = (state_q == FAULT);
  assign bus.RetireCount = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a reference model
module tb_pc_sequencer;
  localparam int DEPTH = 17;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'd0), .IMEM_DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: three mode flags, run is "none of them set".
  bit              m_boot, m_halt, m_fault;
  longint unsigned m_pc, m_ret;

  function automatic longint unsigned wrap32(longint unsigned v);
    return v % 64'h1_0000_0000;
  endfunction

  task automatic model_reset();
    m_boot  = 1'b1;
    m_halt  = 1'b0;
    m_fault = 1'b0;
    m_pc    = 0;
    m_ret   = 0;
  endtask

  task automatic model_edge();
    longint unsigned np;
    if (m_fault) begin
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      if (bus.Resume) begin
        np     = wrap32(m_pc + 1);
        m_halt = 1'b0;
        if (np >= DEPTH) m_fault = 1'b1;
        else             m_pc    = np;
      end
    end else if (bus.Halt) begin
      m_halt = 1'b1;
      m_ret  = wrap32(m_ret + 1);
    end else if (!bus.Stall) begin
      if (bus.Jump)        np = (m_pc & 64'hFC00_0000) | longint'(bus.jump);
      else if (bus.Branch) np = wrap32(m_pc + 1 + longint'(bus.offset));
      else                 np = wrap32(m_pc + 1);
      m_ret = wrap32(m_ret + 1);
      if (np >= DEPTH) m_fault = 1'b1;
      else             m_pc    = np;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("PC", bus.PC, m_pc[31:0]);
    chk("PCValid", 32'(bus.PCValid), 32'(!m_boot && !m_halt && !m_fault));
    chk("Halted", 32'(bus.Halted), 32'(m_halt));
    chk("Fault", 32'(bus.Fault), 32'(m_fault));
    chk("RetireCount", bus.RetireCount, m_ret[31:0]);
  endtask

  task automatic cyc(input bit st, input bit br, input bit jp, input logic [31:0] off,
                     input logic [25:0] jf, input bit hl, input bit rs);
    bus.Stall  = st;
    bus.Branch = br;
    bus.Jump   = jp;
    bus.offset = off;
    bus.jump   = jf;
    bus.Halt   = hl;
    bus.Resume = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 26'd0, 0, 0);
  endtask

  // Pulse reset between clock edges and check the asynchronous effect immediately.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.Stall = 0; bus.Branch = 0; bus.Jump = 0; bus.offset = 0;
    bus.jump = 0; bus.Halt = 0; bus.Resume = 0;
    #12;
    model_reset();
    check_all();
    chk("reset_pc", bus.PC, 32'd0);
    chk("reset_valid", 32'(bus.PCValid), 32'd0);
    #1 rst_n = 1'b1;

    idle(4);
    chk("seq_pc", bus.PC, 32'd3);
    chk("seq_ret", bus.RetireCount, 32'd3);
    idle(1);

    cyc(0, 0, 1, 32'd0, 26'd1, 0, 0);
    chk("jump_pc", bus.PC, 32'd1);
    idle(5);
    cyc(0, 1, 0, 32'd3, 26'd0, 0, 0);
    chk("branch_pc", bus.PC, 32'd10);
    cyc(0, 0, 1, 32'd0, 26'd2, 0, 0);
    cyc(0, 1, 1, 32'd7, 26'd5, 0, 0);
    chk("jump_wins", bus.PC, 32'd5);

    cyc(0, 0, 1, 32'd0, 26'd3, 0, 0);
    cyc(1, 0, 0, 32'd0, 26'd0, 0, 0);
    cyc(1, 1, 0, 32'd4, 26'd0, 0, 0);
    cyc(1, 0, 0, 32'd0, 26'd0, 1, 0);
    chk("halt_pc", bus.PC, 32'd3);
    chk("halt_flag", 32'(bus.Halted), 32'd1);
    cyc(1, 1, 1, 32'd2, 26'd9, 0, 0);
    cyc(0, 0, 0, 32'd0, 26'd0, 0, 1);
    chk("resume_pc", bus.PC, 32'd4);

    cyc(0, 0, 1, 32'd0, 26'd16, 0, 0);
    idle(1);
    chk("fault_flag", 32'(bus.Fault), 32'd1);
    chk("fault_pc", bus.PC, 32'd16);
    cyc(0, 0, 1, 32'd0, 26'd2, 0, 1);
    cyc(0, 1, 0, 32'd1, 26'd0, 1, 1);
    reset_pulse();

    idle(1);
    cyc(0, 0, 1, 32'd0, 26'd10, 0, 0);
    cyc(0, 1, 0, 32'hFFFF_FFF5, 26'd0, 0, 0);
    chk("wrap_pc", bus.PC, 32'd0);
    chk("wrap_valid", 32'(bus.PCValid), 32'd1);
    cyc(0, 0, 1, 32'd0, 26'd10, 0, 0);
    cyc(0, 1, 0, 32'd10, 26'd0, 0, 0);
    chk("branch_fault", 32'(bus.Fault), 32'd1);
    reset_pulse();

    idle(1);
    cyc(0, 0, 1, 32'd0, 26'd7, 0, 0);
    reset_pulse();
    chk("midrun_ret", bus.RetireCount, 32'd0);
    idle(1);
    chk("reboot_valid", 32'(bus.PCValid), 32'd1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] off;
      off = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 8));
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          off, 26'($urandom_range(0, 20)), $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 33) == 0 || (m_fault && $urandom_range(0, 4) == 0)) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
